alu_seq: RTL and testbench
==========================

# alu_seq

Registered, width-parametrised ALU with a Start/Busy/Done handshake. It is the successor to the combinational 16-bit ALU. It keeps the same operation encoding (AND/OR/XOR/ADD/SUB via BNegate) and flags. It adds set-less-than, logical shifts and a multi-cycle shift-add multiplier. It sits in the CPU execute stage. The control unit issues one operation, then consumes REZ and the flags when Done pulses.

## Interface
- WIDTH, 16, operand/result width in bits (≥4, power of two).
- MUL_EN, 1, 1 = multiplier built; 0 = op 110 completes in one cycle with REZ=0 and Overflow=0.

- Clock  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  issue request; sampled only when Busy=0.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- ALUCtrl  input  3  operation select.
- BNegate  input  1  ADD→SUB; SHIFT left→right.
- REZ  output  WIDTH  registered result.
- Zero  output  1  REZ==0.
- Overflow  output  1  signed add/sub overflow, or MUL high half nonzero.
- CarryOut  output  1  adder carry out.
- Busy  output  1  multi-cycle op in progress.
- Done  output  1  one-cycle pulse: REZ and flags updated.

## Operation
- Encoding:
  - 000 AND.
  - 001 NOR.
  - 010 OR.
  - 011 XOR.
  - 100 ADD (BNegate=0) or SUB = A + ~B + 1 (BNegate=1).
  - 101 SLT: REZ = 1 if A < B signed, else 0.
  - 110 MUL: unsigned, REZ = low WIDTH bits of the product.
  - 111 SHIFT: A shifted by B[$clog2(WIDTH)-1:0], left if BNegate=0, logical right if 1.
- Flags:
  - Zero is always (REZ==0).
  - CarryOut is the adder carry for 100 and 0 for all other ops. SUB of equal operands gives CarryOut=1.
  - Overflow for 100 is set when the operand signs, after B inversion, are equal and the result sign differs.
  - Overflow for 110 is set when any bit of product[2·WIDTH-1:WIDTH] is set; it is 0 for all other ops.
  - SLT uses the sign of the subtraction XOR the subtraction overflow. Its own Overflow and CarryOut are 0.
- A, B, ALUCtrl and BNegate are captured at the accepting edge. Input changes after that edge do not affect the operation.
- FSM states:
  - IDLE: on Start with op≠110 or MUL_EN=0, compute and register outputs at the same edge and pulse Done; stay in IDLE. On Start with op 110 and MUL_EN=1, load the multiplicand, multiplier and a 2·WIDTH accumulator, clear the iteration counter, go to MUL, and set Busy=1.
  - MUL: one shift-add iteration per edge. The counter counts 0..WIDTH-1. At the edge completing iteration WIDTH-1, register REZ and the flags, pulse Done, clear Busy and return to IDLE.
- Start while Busy=1 is ignored (no queueing) and does not extend the operation.
- REZ and the flags hold their last values until the next Done.

## Timing
- Reset values: REZ=0, Zero=1, Overflow=0, CarryOut=0, Busy=0, Done=0. State=IDLE, counter=0.
- Single-cycle ops:
  - Start sampled at edge k; REZ, flags and Done=1 are valid after edge k.
  - Latency is 1 cycle.
  - Start held high every cycle gives one result per cycle, with Done continuously high.
- MUL:
  - Start at edge k; Busy=1 after edge k.
  - Done=1 and Busy=0 after edge k+WIDTH, so latency is WIDTH cycles (16 at default).
  - Done is low during Busy.
  - The next Start is accepted at edge k+WIDTH+1 at the earliest, since Start at edge k+WIDTH is seen while Busy=1.
- Reset has priority over everything.
  - Reset mid-MUL aborts: reset values take effect at the next edge and no Done is produced.
  - Reset and Start in the same cycle: Start is dropped.
- Done is never high for two cycles from one Start.

## Test plan
- ADD/SUB (WIDTH=16):
  - 5+5 gives REZ=10, Zero=0, CarryOut=0, Done one cycle after Start.
  - 5−5 gives REZ=0, Zero=1, CarryOut=1.
  - 0x8000−1 gives REZ=0x7FFF, Overflow=1.
  - 0xFFFF+1 gives REZ=0, CarryOut=1, Overflow=0.
- Logic/SLT/SHIFT:
  - XOR 10,20 gives 30.
  - AND 40,30 gives 8.
  - OR 6,3 gives 7.
  - NOR 0,0 gives 0xFFFF.
  - SLT 0xFFFF,1 gives 1; SLT 1,0xFFFF gives 0.
  - SHIFT 1,15 left gives 0x8000; right with A=0x8000,B=15 gives 1.
- MUL:
  - 300×300 gives REZ=0x5F90, Overflow=1.
  - 12×11 gives 132, Overflow=0.
  - Busy is high exactly 16 cycles, with Done one pulse after the 16th edge.
- Busy protection: during a MUL, pulse Start with an ADD and change A/B. Required: the MUL result is unaffected, no extra Done appears, and the ADD is not executed.
- Reset mid-MUL: assert Reset at the 5th Busy cycle. Required: Busy=0, Done=0, REZ=0, Zero=1 after that edge. A following ADD 6+3 then gives REZ=9.
- Back-to-back: Start held high for ADD 1+1, 2+2, 3+3 gives REZ 2,4,6 on consecutive cycles, with Done high throughout.

Source files
------------

// File: rtl/alu_seq.sv
// alu_seq - registered, width-parametrised ALU with a Start/Busy/Done handshake.
//
// Single-cycle ops (AND, NOR, OR, XOR, ADD/SUB, SLT, SHIFT) are computed and
// registered at the edge that accepts Start. MUL (op 110, when MUL_EN=1) runs
// a shift-add multiplier for WIDTH cycles. REZ and the flags hold between
// Done pulses.
//
// Parameters:
//   WIDTH    operand/result width (>=4, power of two)
//   MUL_EN   1 = multiplier built; 0 = op 110 completes in one cycle, REZ=0
// Ports:
//   Clock    rising-edge clock
//   Reset    synchronous, active-high reset
//   Start    issue request, sampled only when Busy=0
//   A, B     operands
//   ALUCtrl  operation select
//   BNegate  ADD->SUB, SHIFT left->right
//   REZ      registered result
//   Zero     REZ==0
//   Overflow signed add/sub overflow, or MUL high half nonzero
//   CarryOut adder carry out (op 100 only)
//   Busy     multi-cycle op in progress
//   Done     one-cycle pulse when REZ and the flags update
module alu_seq #(
    parameter int unsigned WIDTH  = 16,
    parameter bit          MUL_EN = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [2:0]       ALUCtrl,
    input  logic             BNegate,
    output logic [WIDTH-1:0] REZ,
    output logic             Zero,
    output logic             Overflow,
    output logic             CarryOut,
    output logic             Busy,
    output logic             Done
);

    localparam int unsigned SW = $clog2(WIDTH);
    localparam logic [SW-1:0] CNT_LAST = SW'(WIDTH - 1);

    typedef enum logic {
        S_IDLE,
        S_MUL
    } state_t;

    state_t state;

    // Multiplier datapath
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [SW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc_next;

    // Single-cycle datapath
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   add_full;
    logic [WIDTH-1:0] sub_w;
    logic             add_ovf;
    logic             sub_ovf;
    logic [SW-1:0]    shamt;
    logic [WIDTH-1:0] nxt_rez;
    logic             nxt_c;
    logic             nxt_v;

    always_comb begin
        b_eff    = BNegate ? ~B : B;
        add_full = {1'b0, A} + {1'b0, b_eff} + {{WIDTH{1'b0}}, BNegate};
        // Overflow when the operand signs (after inversion) agree but the result sign differs
        add_ovf  = (A[WIDTH-1] == b_eff[WIDTH-1]) && (add_full[WIDTH-1] != A[WIDTH-1]);
        // SLT always subtracts, independent of BNegate
        sub_w    = A + ~B + {{(WIDTH-1){1'b0}}, 1'b1};
        sub_ovf  = (A[WIDTH-1] != B[WIDTH-1]) && (sub_w[WIDTH-1] != A[WIDTH-1]);
        shamt    = B[SW-1:0];

        nxt_rez = '0;
        nxt_c   = 1'b0;
        nxt_v   = 1'b0;
        case (ALUCtrl)
            3'b000: nxt_rez = A & B;
            3'b001: nxt_rez = ~(A | B);
            3'b010: nxt_rez = A | B;
            3'b011: nxt_rez = A ^ B;
            3'b100: begin
                nxt_rez = add_full[WIDTH-1:0];
                nxt_c   = add_full[WIDTH];
                nxt_v   = add_ovf;
            end
            3'b101: nxt_rez = {{(WIDTH-1){1'b0}}, sub_w[WIDTH-1] ^ sub_ovf};
            3'b110: nxt_rez = '0;  // reached only when the multiplier is not built
            3'b111: nxt_rez = BNegate ? (A >> shamt) : (A << shamt);
            default: nxt_rez = '0;
        endcase
    end

    always_comb begin
        acc_next = acc + (mplier[0] ? mcand : '0);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= S_IDLE;
            REZ      <= '0;
            Zero     <= 1'b1;
            Overflow <= 1'b0;
            CarryOut <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        if (MUL_EN && (ALUCtrl == 3'b110)) begin
                            mcand  <= {{WIDTH{1'b0}}, A};
                            mplier <= B;
                            acc    <= '0;
                            cnt    <= '0;
                            Busy   <= 1'b1;
                            state  <= S_MUL;
                        end else begin
                            REZ      <= nxt_rez;
                            Zero     <= (nxt_rez == '0);
                            CarryOut <= nxt_c;
                            Overflow <= nxt_v;
                            Done     <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        // acc_next already holds the full product at the last iteration
                        REZ      <= acc_next[WIDTH-1:0];
                        Zero     <= (acc_next[WIDTH-1:0] == '0);
                        Overflow <= |acc_next[2*WIDTH-1:WIDTH];
                        CarryOut <= 1'b0;
                        Done     <= 1'b1;
                        Busy     <= 1'b0;
                        cnt      <= '0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;

    logic        Clock;
    logic        Reset;
    logic        Start;
    logic [15:0] A;
    logic [15:0] B;
    logic [2:0]  ALUCtrl;
    logic        BNegate;
    logic [15:0] REZ;
    logic        Zero;
    logic        Overflow;
    logic        CarryOut;
    logic        Busy;
    logic        Done;

    int unsigned checks;
    int unsigned failures;

    alu_seq #(.WIDTH(16), .MUL_EN(1'b1)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Start   (Start),
        .A       (A),
        .B       (B),
        .ALUCtrl (ALUCtrl),
        .BNegate (BNegate),
        .REZ     (REZ),
        .Zero    (Zero),
        .Overflow(Overflow),
        .CarryOut(CarryOut),
        .Busy    (Busy),
        .Done    (Done)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [2:0]  op;
        logic        bn;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] rez;
        logic        z;
        logic        c;
        logic        v;
    } vec_t;

    // Drive one request at the falling edge, return just after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic bn, input logic [15:0] a, input logic [15:0] b);
        @(negedge Clock);
        ALUCtrl = op;
        BNegate = bn;
        A       = a;
        B       = b;
        Start   = 1'b1;
        @(posedge Clock);
        #1;
        Start = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge Clock);
        Reset = 1'b1;
        Start = 1'b1;           // Start together with Reset must be dropped
        ALUCtrl = 3'b100; BNegate = 1'b0; A = 16'd7; B = 16'd8;
        repeat (2) @(posedge Clock);
        #1;
        checks++;
        if (REZ !== 16'h0000 || Zero !== 1'b1 || Overflow !== 1'b0 || CarryOut !== 1'b0 ||
            Busy !== 1'b0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL reset: REZ=%h Z=%b V=%b C=%b Busy=%b Done=%b required 0000 1 0 0 0 0",
                     REZ, Zero, Overflow, CarryOut, Busy, Done);
        end
        @(negedge Clock);
        Start = 1'b0;
        Reset = 1'b0;
    endtask

    task automatic test_add_sub;
        vec_t v[4];
        v[0] = '{3'b100, 1'b0, 16'd5,     16'd5,     16'd10,    1'b0, 1'b0, 1'b0};
        v[1] = '{3'b100, 1'b1, 16'd5,     16'd5,     16'd0,     1'b1, 1'b1, 1'b0};
        v[2] = '{3'b100, 1'b1, 16'h8000,  16'd1,     16'h7FFF,  1'b0, 1'b1, 1'b1};
        v[3] = '{3'b100, 1'b0, 16'hFFFF,  16'd1,     16'h0000,  1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            issue(v[i].op, v[i].bn, v[i].a, v[i].b);
            checks++;
            if (REZ !== v[i].rez || Zero !== v[i].z || CarryOut !== v[i].c ||
                Overflow !== v[i].v || Done !== 1'b1) begin
                failures++;
                $display("FAIL add_sub[%0d]: REZ=%h Z=%b C=%b V=%b Done=%b required %h %b %b %b 1",
                         i, REZ, Zero, CarryOut, Overflow, Done, v[i].rez, v[i].z, v[i].c, v[i].v);
            end
        end
        @(posedge Clock);
        #1;
        checks++;
        if (Done !== 1'b0 || REZ !== 16'h0000 || CarryOut !== 1'b1) begin
            failures++;
            $display("FAIL done_pulse_hold: Done=%b REZ=%h C=%b required 0 0000 1", Done, REZ, CarryOut);
        end
    endtask

    task automatic test_logic_slt_shift;
        vec_t v[8];
        v[0] = '{3'b011, 1'b0, 16'd10,    16'd20,    16'd30,    1'b0, 1'b0, 1'b0};
        v[1] = '{3'b000, 1'b0, 16'd40,    16'd30,    16'd8,     1'b0, 1'b0, 1'b0};
        v[2] = '{3'b010, 1'b0, 16'd6,     16'd3,     16'd7,     1'b0, 1'b0, 1'b0};
        v[3] = '{3'b001, 1'b0, 16'd0,     16'd0,     16'hFFFF,  1'b0, 1'b0, 1'b0};
        v[4] = '{3'b101, 1'b0, 16'hFFFF,  16'd1,     16'd1,     1'b0, 1'b0, 1'b0};
        v[5] = '{3'b101, 1'b0, 16'd1,     16'hFFFF,  16'd0,     1'b1, 1'b0, 1'b0};
        v[6] = '{3'b111, 1'b0, 16'd1,     16'd15,    16'h8000,  1'b0, 1'b0, 1'b0};
        v[7] = '{3'b111, 1'b1, 16'h8000,  16'd15,    16'd1,     1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 8; i++) begin
            issue(v[i].op, v[i].bn, v[i].a, v[i].b);
            checks++;
            if (REZ !== v[i].rez || Zero !== v[i].z || CarryOut !== v[i].c ||
                Overflow !== v[i].v || Done !== 1'b1) begin
                failures++;
                $display("FAIL logic[%0d]: REZ=%h Z=%b C=%b V=%b Done=%b required %h %b %b %b 1",
                         i, REZ, Zero, CarryOut, Overflow, Done, v[i].rez, v[i].z, v[i].c, v[i].v);
            end
        end
    endtask

    task automatic test_mul;
        int unsigned busy_cnt;
        int unsigned done_at;
        int unsigned early_done;
        logic [15:0] prev_rez;
        vec_t v[2];
        v[0] = '{3'b110, 1'b0, 16'd300, 16'd300, 16'h5F90, 1'b0, 1'b0, 1'b1};
        v[1] = '{3'b110, 1'b0, 16'd12,  16'd11,  16'd132,  1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 2; i++) begin
            prev_rez   = REZ;
            issue(v[i].op, v[i].bn, v[i].a, v[i].b);
            busy_cnt   = (Busy === 1'b1) ? 1 : 0;
            early_done = (Done === 1'b1) ? 1 : 0;
            done_at    = 0;
            for (int e = 1; e <= 30 && done_at == 0; e++) begin
                if (REZ !== prev_rez) early_done++;
                @(posedge Clock);
                #1;
                if (Done === 1'b1) done_at = e;
                else if (Busy === 1'b1) busy_cnt++;
            end
            checks++;
            if (done_at != 16 || busy_cnt != 16 || early_done != 0 || Busy !== 1'b0) begin
                failures++;
                $display("FAIL mul_timing[%0d]: done_edge=%0d busy_cycles=%0d early=%0d Busy=%b required 16 16 0 0",
                         i, done_at, busy_cnt, early_done, Busy);
            end
            checks++;
            if (REZ !== v[i].rez || Overflow !== v[i].v || Zero !== v[i].z || CarryOut !== v[i].c) begin
                failures++;
                $display("FAIL mul_result[%0d]: REZ=%h V=%b Z=%b C=%b required %h %b %b %b",
                         i, REZ, Overflow, Zero, CarryOut, v[i].rez, v[i].v, v[i].z, v[i].c);
            end
            @(posedge Clock);
            #1;
            checks++;
            if (Done !== 1'b0) begin
                failures++;
                $display("FAIL mul_done_pulse[%0d]: Done=%b required 0", i, Done);
            end
        end
    endtask

    task automatic test_busy_protect;
        int unsigned done_cnt;
        int unsigned done_at;
        issue(3'b110, 1'b0, 16'd7, 16'd9);
        done_cnt = 0;
        done_at  = 0;
        for (int e = 1; e <= 22; e++) begin
            @(negedge Clock);
            if (e == 3 || e == 4 || e == 16) begin
                ALUCtrl = 3'b100; BNegate = 1'b0;
                A = 16'd1000 + 16'(e); B = 16'd1;
                Start = 1'b1;
            end else begin
                Start = 1'b0;
            end
            @(posedge Clock);
            #1;
            if (Done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = e;
            end
        end
        Start = 1'b0;
        checks++;
        if (done_cnt != 1 || done_at != 16) begin
            failures++;
            $display("FAIL busy_protect_done: pulses=%0d first_edge=%0d required 1 16", done_cnt, done_at);
        end
        checks++;
        if (REZ !== 16'd63 || Overflow !== 1'b0 || CarryOut !== 1'b0) begin
            failures++;
            $display("FAIL busy_protect_result: REZ=%h V=%b C=%b required 003f 0 0", REZ, Overflow, CarryOut);
        end
    endtask

    task automatic test_reset_mid_mul;
        int unsigned done_cnt;
        issue(3'b110, 1'b0, 16'd300, 16'd300);
        for (int e = 1; e <= 4; e++) begin
            @(posedge Clock);
        end
        @(negedge Clock);
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0 || REZ !== 16'h0000 || Zero !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_mul: Busy=%b Done=%b REZ=%h Z=%b required 0 0 0000 1",
                     Busy, Done, REZ, Zero);
        end
        Reset = 1'b0;
        done_cnt = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge Clock);
            #1;
            if (Done === 1'b1 || Busy === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 0) begin
            failures++;
            $display("FAIL reset_abort: done_or_busy_cycles=%0d required 0", done_cnt);
        end
        issue(3'b100, 1'b0, 16'd6, 16'd3);
        checks++;
        if (REZ !== 16'd9 || Done !== 1'b1 || Zero !== 1'b0) begin
            failures++;
            $display("FAIL after_reset_add: REZ=%h Done=%b Z=%b required 0009 1 0", REZ, Done, Zero);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge Clock);
        ALUCtrl = 3'b100; BNegate = 1'b0; A = 16'd1; B = 16'd1;
        Start = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            @(posedge Clock);
            #1;
            checks++;
            if (REZ !== 16'(2 * i) || Done !== 1'b1) begin
                failures++;
                $display("FAIL back_to_back[%0d]: REZ=%h Done=%b required %h 1", i, REZ, Done, 16'(2 * i));
            end
            A = 16'(i + 1);
            B = 16'(i + 1);
            if (i == 3) Start = 1'b0;
        end
        @(posedge Clock);
        #1;
        checks++;
        if (Done !== 1'b0 || REZ !== 16'd6) begin
            failures++;
            $display("FAIL back_to_back_end: Done=%b REZ=%h required 0 0006", Done, REZ);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        Reset    = 1'b1;
        Start    = 1'b0;
        A        = '0;
        B        = '0;
        ALUCtrl  = '0;
        BNegate  = 1'b0;
        test_reset();
        test_add_sub();
        test_logic_slt_shift();
        test_mul();
        test_busy_protect();
        test_reset_mid_mul();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
